spi_bus_arbiter: RTL and testbench

Shares the single physical SPI port (shared `sclk`/`mosi`, per-device `spi_ncs`, `miso` routed by active chip select) between two SPI masters: requester 0 (the SoC SPI controller) and requester 1 (a hardware boot/flash loader).

- Grants ownership with a round-robin request/grant handshake and never truncates a transfer.
- Inserts a guard interval, with all chip selects deasserted, between owners.
- Registers all pad-facing outputs.
- Sits between the SoC SPI master(s) and the board-level SPI pins in the FPGA top level.

---
 rtl/spi_arb_pkg.sv | 7 +
 rtl/spi_miso_route.sv | 15 +
 rtl/spi_bus_arbiter.sv | 96 +++++++++
 tb/tb_spi_bus_arbiter.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state type and idle-pad constants for the SPI bus arbiter
package spi_arb_pkg;
   typedef enum logic [1:0] {IDLE, OWN0, OWN1, GUARD} arb_state_t;
   localparam logic SPI_IDLE_CLK  = 1'b0;
   localparam logic SPI_IDLE_MOSI = 1'b1;
   localparam int   GUARD_CNT_W   = 8;
endpackage

// File: rtl/spi_miso_route.sv
// spi_miso_route: picks the MISO bit of the lowest active chip select on the pads
module spi_miso_route #(
   parameter int spi_num_cs = 2
) (
   input  logic [spi_num_cs-1:0] spi_ncs,
   input  logic [spi_num_cs-1:0] spi_miso,
   output logic                  miso
);
   // scan downward so the lowest-numbered active select overrides; idle line reads high
   always_comb begin
      miso = 1'b1;
      for (int i = spi_num_cs - 1; i >= 0; i--)
         if (!spi_ncs[i]) miso = spi_miso[i];
   end
endmodule

// File: rtl/spi_bus_arbiter.sv
// spi_bus_arbiter: round-robin sharing of one SPI pad set between two masters with a guard gap
module spi_bus_arbiter
   import spi_arb_pkg::*;
#(
   parameter int spi_num_cs   = 2,
   parameter int guard_cycles = 4
) (
   input  logic                  clk,
   input  logic                  rst_in_n,
   input  logic                  req0,
   input  logic                  req1,
   output logic                  gnt0,
   output logic                  gnt1,
   input  logic [spi_num_cs-1:0] ncs0,
   input  logic [spi_num_cs-1:0] ncs1,
   input  logic                  sclk0,
   input  logic                  sclk1,
   input  logic                  mosi0,
   input  logic                  mosi1,
   output logic                  miso0,
   output logic                  miso1,
   output logic [spi_num_cs-1:0] spi_ncs,
   output logic                  spi_clk,
   output logic                  spi_mosi,
   input  logic [spi_num_cs-1:0] spi_miso,
   output logic                  bus_busy
);
   localparam logic [GUARD_CNT_W-1:0] GUARD_LOAD = GUARD_CNT_W'(guard_cycles - 1);

   arb_state_t             state;
   logic                   last_owner;
   logic [GUARD_CNT_W-1:0] guard_cnt;
   logic                   miso_bit;

   // ownership FSM: grants only from IDLE, releases only once the owner's transfer has ended
   always_ff @(posedge clk) begin
      if (!rst_in_n) begin
         state      <= IDLE;
         gnt0       <= 1'b0;
         gnt1       <= 1'b0;
         last_owner <= 1'b1;
         guard_cnt  <= '0;
      end else begin
         case (state)
            IDLE:
               if (req0 && (!req1 || last_owner)) begin
                  state <= OWN0;
                  gnt0  <= 1'b1;
               end else if (req1) begin
                  state <= OWN1;
                  gnt1  <= 1'b1;
               end
            OWN0:
               if (!req0 && &ncs0) begin
                  state      <= GUARD;
                  gnt0       <= 1'b0;
                  last_owner <= 1'b0;
                  guard_cnt  <= GUARD_LOAD;
               end
            OWN1:
               if (!req1 && &ncs1) begin
                  state      <= GUARD;
                  gnt1       <= 1'b0;
                  last_owner <= 1'b1;
                  guard_cnt  <= GUARD_LOAD;
               end
            GUARD:
               if (guard_cnt == '0) state <= IDLE;
               else guard_cnt <= guard_cnt - 1'b1;
         endcase
      end
   end

   // pad registers follow the current owner; reset forces chip selects high with no guard
   always_ff @(posedge clk) begin
      if (!rst_in_n) begin
         spi_ncs  <= '1;
         spi_clk  <= SPI_IDLE_CLK;
         spi_mosi <= SPI_IDLE_MOSI;
      end else begin
         spi_ncs  <= (state == OWN0) ? ncs0  : (state == OWN1) ? ncs1  : '1;
         spi_clk  <= (state == OWN0) ? sclk0 : (state == OWN1) ? sclk1 : SPI_IDLE_CLK;
         spi_mosi <= (state == OWN0) ? mosi0 : (state == OWN1) ? mosi1 : SPI_IDLE_MOSI;
      end
   end

   spi_miso_route #(.spi_num_cs(spi_num_cs)) u_miso_route (
      .spi_ncs (spi_ncs),
      .spi_miso(spi_miso),
      .miso    (miso_bit)
   );

   assign miso0    = (state == OWN0) ? miso_bit : 1'b1;
   assign miso1    = (state == OWN1) ? miso_bit : 1'b1;
   assign bus_busy = (state != IDLE);
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb_spi_bus_arbiter: directed and random checks of the arbiter against an ownership model
module tb_spi_bus_arbiter;
   localparam int G = 4;

   logic       clk = 1'b0;
   logic       rst_in_n = 1'b0;
   logic       req0 = 1'b0, req1 = 1'b0;
   logic       gnt0, gnt1;
   logic [1:0] ncs0 = 2'b11, ncs1 = 2'b11;
   logic       sclk0 = 1'b0, sclk1 = 1'b0, mosi0 = 1'b0, mosi1 = 1'b0;
   logic       miso0, miso1;
   logic [1:0] spi_ncs;
   logic       spi_clk, spi_mosi;
   logic [1:0] spi_miso = 2'b00;
   logic       bus_busy;

   int checks = 0, failures = 0;
   int m_owner = -1, m_guard = 0, m_last = 1;
   logic [1:0] m_ncs = 2'b11;
   logic m_clk = 1'b0, m_mosi = 1'b1;

   spi_bus_arbiter #(.spi_num_cs(2), .guard_cycles(G)) dut (
      .clk(clk), .rst_in_n(rst_in_n), .req0(req0), .req1(req1), .gnt0(gnt0), .gnt1(gnt1),
      .ncs0(ncs0), .ncs1(ncs1), .sclk0(sclk0), .sclk1(sclk1), .mosi0(mosi0), .mosi1(mosi1),
      .miso0(miso0), .miso1(miso1), .spi_ncs(spi_ncs), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .bus_busy(bus_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic exp_miso(input int x);
      if (m_owner != x) return 1'b1;
      for (int i = 0; i < 2; i++) if (!m_ncs[i]) return spi_miso[i];
      return 1'b1;
   endfunction

   task automatic step();
      logic rq;
      logic [1:0] nc;
      @(posedge clk);
      if (!rst_in_n) begin
         m_owner = -1; m_guard = 0; m_last = 1;
         m_ncs = 2'b11; m_clk = 1'b0; m_mosi = 1'b1;
      end else begin
         m_ncs  = (m_owner == 0) ? ncs0  : (m_owner == 1) ? ncs1  : 2'b11;
         m_clk  = (m_owner == 0) ? sclk0 : (m_owner == 1) ? sclk1 : 1'b0;
         m_mosi = (m_owner == 0) ? mosi0 : (m_owner == 1) ? mosi1 : 1'b1;
         if (m_owner >= 0) begin
            rq = (m_owner == 0) ? req0 : req1;
            nc = (m_owner == 0) ? ncs0 : ncs1;
            if (!rq && nc == 2'b11) begin
               m_last = m_owner; m_owner = -1; m_guard = G;
            end
         end else if (m_guard > 0) m_guard--;
         else if (req0 && req1) m_owner = 1 - m_last;
         else if (req0) m_owner = 0;
         else if (req1) m_owner = 1;
      end
      #1;
      check("gnt0", gnt0, m_owner == 0);
      check("gnt1", gnt1, m_owner == 1);
      check("bus_busy", bus_busy, m_owner >= 0 || m_guard > 0);
      check("spi_ncs", spi_ncs, m_ncs);
      check("spi_clk", spi_clk, m_clk);
      check("spi_mosi", spi_mosi, m_mosi);
      check("miso0", miso0, exp_miso(0));
      check("miso1", miso1, exp_miso(1));
   endtask

   int held0, held1, last_g, gap, grants, glen, g;
   logic pg0, pg1;

   initial begin
      // reset state
      repeat (2) step();
      check("rst_gnt", {gnt0, gnt1}, 2'b00);
      check("rst_pads", {spi_ncs, spi_clk, spi_mosi}, 4'b1101);
      rst_in_n = 1'b1;
      // single requester
      req0 = 1'b1;
      step();
      check("single_gnt0", gnt0, 1);
      check("single_miso1", miso1, 1);
      ncs0 = 2'b10;
      step();
      check("single_ncs", spi_ncs, 2'b10);
      repeat (4) begin
         spi_miso = 2'($urandom);
         #1;
         check("single_miso0", miso0, spi_miso[0]);
      end
      // no truncation: request drops mid-transfer
      req0 = 1'b0;
      repeat (3) begin
         step();
         check("hold_gnt0", gnt0, 1);
      end
      ncs0 = 2'b11;
      step();
      check("release_gnt0", gnt0, 0);
      repeat (6) step();
      // tie after reset
      rst_in_n = 1'b0;
      step();
      rst_in_n = 1'b1;
      req0 = 1'b1; req1 = 1'b1;
      step();
      check("tie_first", gnt0, 1);
      req0 = 1'b0;
      glen = 0;
      for (int c = 0; c < 20 && !gnt1; c++) begin
         step();
         if (bus_busy && !gnt0 && !gnt1 && spi_ncs == 2'b11) glen++;
      end
      check("tie_gnt1", gnt1, 1);
      check("tie_guard_len", glen, G);
      // reset mid-transfer
      ncs1 = 2'b01; mosi1 = 1'b0;
      for (int c = 0; c < 4; c++) begin
         sclk1 = ~sclk1;
         step();
      end
      rst_in_n = 1'b0;
      step();
      check("midrst_ncs", spi_ncs, 2'b11);
      check("midrst_clk", spi_clk, 0);
      check("midrst_mosi", spi_mosi, 1);
      check("midrst_gnt1", gnt1, 0);
      rst_in_n = 1'b1;
      // round-robin fairness with continuous re-requests
      req0 = 1'b1; req1 = 1'b1; ncs0 = 2'b11; ncs1 = 2'b11;
      held0 = 0; held1 = 0; last_g = 1; gap = 0; grants = 0; pg0 = 1'b0; pg1 = 1'b0;
      for (int c = 0; c < 1000; c++) begin
         step();
         if ((gnt0 && !pg0) || (gnt1 && !pg1)) begin
            g = gnt1 ? 1 : 0;
            check("rr_alt", g, 1 - last_g);
            if (grants > 0) check("rr_gap", gap >= G, 1);
            last_g = g; grants++; gap = 0;
         end else if (!gnt0 && !gnt1) gap++;
         pg0 = gnt0; pg1 = gnt1;
         sclk0 = 1'($urandom); mosi0 = 1'($urandom); sclk1 = 1'($urandom); mosi1 = 1'($urandom);
         spi_miso = 2'($urandom);
         if (m_owner == 0) begin
            held0++; req0 = held0 < 3; ncs0 = (held0 < 3) ? 2'b10 : 2'b11;
         end else begin
            held0 = 0; req0 = 1'b1; ncs0 = 2'b11;
         end
         if (m_owner == 1) begin
            held1++; req1 = held1 < 3; ncs1 = (held1 < 3) ? 2'b01 : 2'b11;
         end else begin
            held1 = 0; req1 = 1'b1; ncs1 = 2'b11;
         end
      end
      check("rr_count", grants >= 100, 1);
      // random traffic, non-owner noise and occasional reset
      for (int c = 0; c < 3000; c++) begin
         step();
         rst_in_n = $urandom_range(0, 63) != 0;
         req0 = $urandom_range(0, 3) != 0;
         req1 = $urandom_range(0, 3) != 0;
         ncs0 = $urandom_range(0, 1) ? 2'b11 : 2'($urandom);
         ncs1 = $urandom_range(0, 1) ? 2'b11 : 2'($urandom);
         sclk0 = 1'($urandom); mosi0 = 1'($urandom); sclk1 = 1'($urandom); mosi1 = 1'($urandom);
         spi_miso = 2'($urandom);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
